// File: rtl/secret_number_gen_pkg.sv
// Shared definitions for the guessing-game secret generator: number width,
// LFSR polynomial, draw FSM encoding and the default legal range.
package secret_number_gen_pkg;

    localparam int NUM_W = 7;

    // x^7 + x^6 + 1: feedback taps on bits 6 and 5.
    localparam logic [NUM_W-1:0] LFSR_TAP = 7'h60;

    localparam logic [NUM_W-1:0] DEFAULT_MIN = 7'd1;
    localparam logic [NUM_W-1:0] DEFAULT_MAX = 7'd99;

    typedef enum logic {
        DRAW  = 1'b0,
        READY = 1'b1
    } draw_state_t;

    function automatic logic [NUM_W-1:0] lfsr_next(input logic [NUM_W-1:0] v);
        return {v[NUM_W-2:0], ^(v & LFSR_TAP)};
    endfunction

endpackage

// File: rtl/secret_number_gen_lfsr7.sv
// Free-running 7-bit Fibonacci LFSR with synchronous seed load.
// A zero seed is replaced by 1 so the register can never lock up.
module lfsr7
    import secret_number_gen_pkg::*;
#(
    parameter logic [NUM_W-1:0] SEED = 7'h5A
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [NUM_W-1:0] load_val,
    output logic [NUM_W-1:0] value
);

    logic [NUM_W-1:0] value_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_reg <= SEED;
        end else if (load) begin
            value_reg <= (load_val == '0) ? NUM_W'(1) : load_val;
        end else begin
            value_reg <= lfsr_next(value_reg);
        end
    end

    assign value = value_reg;

endmodule

// File: rtl/secret_number_gen.sv
// Draws a secret in [MIN_VAL, MAX_VAL] from the LFSR after reset or new_game,
// falling back to MIN_VAL after MAX_TRIES rejected draws, then holds it.
module secret_number_gen
    import secret_number_gen_pkg::*;
#(
    parameter logic [NUM_W-1:0] SEED_DEFAULT = 7'h5A,
    parameter logic [NUM_W-1:0] MIN_VAL      = DEFAULT_MIN,
    parameter logic [NUM_W-1:0] MAX_VAL      = DEFAULT_MAX,
    parameter int               MAX_TRIES    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             new_game,
    input  logic             seed_load,
    input  logic [NUM_W-1:0] seed,
    output logic [NUM_W-1:0] actual_number,
    output logic             number_valid,
    output logic             draw_busy
);

    localparam logic [7:0] LAST_TRY = 8'(MAX_TRIES - 1);

    logic [NUM_W-1:0] lfsr_value;
    logic             in_range;

    draw_state_t      state_reg;
    logic [NUM_W-1:0] number_reg;
    logic             valid_reg;
    logic             busy_reg;
    logic [7:0]       try_cnt_reg;

    lfsr7 #(
        .SEED (SEED_DEFAULT)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (seed_load),
        .load_val (seed),
        .value    (lfsr_value)
    );

    assign in_range = (lfsr_value >= MIN_VAL) && (lfsr_value <= MAX_VAL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= DRAW;
            number_reg  <= '0;
            valid_reg   <= 1'b0;
            busy_reg    <= 1'b1;
            try_cnt_reg <= '0;
        end else begin
            case (state_reg)
                DRAW: begin
                    // new_game is deliberately not looked at while drawing.
                    if (in_range) begin
                        number_reg  <= lfsr_value;
                        valid_reg   <= 1'b1;
                        busy_reg    <= 1'b0;
                        try_cnt_reg <= '0;
                        state_reg   <= READY;
                    end else if (try_cnt_reg == LAST_TRY) begin
                        number_reg  <= MIN_VAL;
                        valid_reg   <= 1'b1;
                        busy_reg    <= 1'b0;
                        try_cnt_reg <= '0;
                        state_reg   <= READY;
                    end else begin
                        try_cnt_reg <= try_cnt_reg + 8'd1;
                    end
                end
                READY: begin
                    if (new_game) begin
                        number_reg  <= '0;
                        valid_reg   <= 1'b0;
                        busy_reg    <= 1'b1;
                        try_cnt_reg <= '0;
                        state_reg   <= DRAW;
                    end
                end
            endcase
        end
    end

    assign actual_number = number_reg;
    assign number_valid  = valid_reg;
    assign draw_busy     = busy_reg;

endmodule

// File: tb/tb_secret_number_gen.sv
// Two generator instances (default range, and a 100..100 / 4-try fallback
// variant) checked every cycle against a per-instance behavioural model.
module tb_secret_number_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       new_game;
    logic       seed_load;
    logic [6:0] seed;

    logic [6:0] num_a, num_b;
    logic       valid_a, valid_b, busy_a, busy_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    secret_number_gen dut_a (
        .clk           (clk),
        .reset         (reset),
        .new_game      (new_game),
        .seed_load     (seed_load),
        .seed          (seed),
        .actual_number (num_a),
        .number_valid  (valid_a),
        .draw_busy     (busy_a)
    );

    secret_number_gen #(
        .MIN_VAL   (7'd100),
        .MAX_VAL   (7'd100),
        .MAX_TRIES (4)
    ) dut_b (
        .clk           (clk),
        .reset         (reset),
        .new_game      (new_game),
        .seed_load     (seed_load),
        .seed          (seed),
        .actual_number (num_b),
        .number_valid  (valid_b),
        .draw_busy     (busy_b)
    );

    typedef struct {
        int lfsr;
        bit drawing;
        int num;
        int tries;
        int mn;
        int mx;
        int mt;
    } model_t;

    model_t m[2];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset(inout model_t s);
        s.lfsr    = 'h5A;
        s.drawing = 1'b1;
        s.num     = 0;
        s.tries   = 0;
    endfunction

    // One clock edge of the game rules: the secret search looks at the
    // current random value; the random source moves on independently.
    function automatic void model_step(inout model_t s, input bit ng, input bit sl, input int sd);
        int nxt;
        if (sl) nxt = (sd == 0) ? 1 : sd;
        else    nxt = ((s.lfsr * 2) % 128) + (((s.lfsr / 64) + (s.lfsr / 32)) % 2);
        if (s.drawing) begin
            if (s.lfsr >= s.mn && s.lfsr <= s.mx) begin
                s.num = s.lfsr; s.drawing = 1'b0; s.tries = 0;
            end else if (s.tries + 1 == s.mt) begin
                s.num = s.mn; s.drawing = 1'b0; s.tries = 0;
            end else begin
                s.tries++;
            end
        end else if (ng) begin
            s.num = 0; s.drawing = 1'b1; s.tries = 0;
        end
        s.lfsr = nxt;
    endfunction

    task automatic compare_all(input string tag);
        chk({tag, "_num_a"},   int'(num_a),   m[0].num);
        chk({tag, "_valid_a"}, int'(valid_a), int'(!m[0].drawing));
        chk({tag, "_busy_a"},  int'(busy_a),  int'(m[0].drawing));
        chk({tag, "_num_b"},   int'(num_b),   m[1].num);
        chk({tag, "_valid_b"}, int'(valid_b), int'(!m[1].drawing));
        chk({tag, "_busy_b"},  int'(busy_b),  int'(m[1].drawing));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!reset) model_reset(m[i]);
            else        model_step(m[i], new_game, seed_load, int'(seed));
        end
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic drive(input string tag, input bit ng, input bit sl, input int sd);
        new_game  = ng;
        seed_load = sl;
        seed      = 7'(sd);
        tick(tag);
        new_game  = 1'b0;
        seed_load = 1'b0;
        $display("txn %-8s new_game=%0d seed_load=%0d seed=0x%02h -> a=%0d/%0d b=%0d/%0d",
                 tag, ng, sl, sd, num_a, valid_a, num_b, valid_b);
    endtask

    task automatic settle(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    initial begin
        m[0].mn = 1;   m[0].mx = 99;  m[0].mt = 16;
        m[1].mn = 100; m[1].mx = 100; m[1].mt = 4;
        model_reset(m[0]);
        model_reset(m[1]);
        reset     = 1'b0;
        new_game  = 1'b0;
        seed_load = 1'b0;
        seed      = '0;

        // 1: reset, release, default seed 0x5A is in range for instance A
        settle("rst", 3);
        reset = 1'b1;
        tick("t1");
        chk("t1_secret", int'(num_a), 'h5A);
        chk("t1_valid", int'(valid_a), 1);
        settle("t1s", 5);
        chk("t1_fallback_b", int'(num_b), 100);

        // 2: in-range seed loaded with the request becomes the secret
        drive("t2req", 1, 1, 'h05);
        chk("t2_busy", int'(busy_a), 1);
        tick("t2");
        chk("t2_secret", int'(num_a), 5);
        settle("t2s", 6);

        // 3: out-of-range seed rejected, its successor 0x60 accepted
        drive("t3req", 1, 1, 'h70);
        settle("t3", 2);
        chk("t3_secret", int'(num_a), 96);
        settle("t3s", 6);

        // 4: instance B rejects 1,2,4,8 then falls back to 100
        drive("t4req", 1, 1, 'h01);
        settle("t4", 4);
        chk("t4_fallback", int'(num_b), 100);
        chk("t4_valid", int'(valid_b), 1);
        settle("t4s", 2);

        // 5: zero seed becomes 1, then the LFSR keeps moving (2 -> 4)
        drive("t5req", 1, 1, 0);
        tick("t5");
        chk("t5_secret", int'(num_a), 1);
        drive("t5req2", 1, 0, 0);
        tick("t5b");
        chk("t5_advanced", int'(num_a), 4);
        settle("t5s", 6);

        // 6a: new_game during DRAW is ignored; one draw completes and holds
        drive("t6req", 1, 1, 'h70);
        drive("t6ign", 1, 0, 0);
        tick("t6");
        chk("t6_secret", int'(num_a), 96);
        tick("t6hold");
        chk("t6_hold", int'(num_a), 96);
        settle("t6s", 6);

        // 6b: asynchronous reset mid-DRAW takes effect without a clock edge
        drive("t6rq", 1, 1, 'h70);
        #2 reset = 1'b0;
        #1;
        model_reset(m[0]);
        model_reset(m[1]);
        compare_all("t6rst");
        chk("t6rst_valid", int'(valid_a), 0);
        settle("t6rl", 2);
        reset = 1'b1;
        tick("t6rel");
        chk("t6rel_secret", int'(num_a), 'h5A);
        settle("t6rs", 5);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            int sd;
            sd = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 127));
            new_game  = ($urandom_range(0, 3) == 0);
            seed_load = ($urandom_range(0, 7) == 0);
            seed      = 7'(sd);
            tick("rnd");
        end
        new_game  = 1'b0;
        seed_load = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/secret_number_gen.md
Name: secret_number_gen

Overview:
- Upstream stage of the up/down guessing-game top. Produces the secret `actual_number` consumed by the comparator, replacing the fixed constant.
- A free-running 7-bit LFSR supplies entropy. On reset or a new-game request, the block draws LFSR values until one falls in [MIN_VAL, MAX_VAL], then latches it and holds it stable for the whole round.

Parameters:
- SEED_DEFAULT, 7'h5A, LFSR value loaded on reset; must be nonzero.
- MIN_VAL, 7'd1, smallest legal secret.
- MAX_VAL, 7'd99, largest legal secret; MIN_VAL <= MAX_VAL <= 127.
- MAX_TRIES, 16, DRAW cycles allowed before the deterministic fallback; range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- new_game  in  1  single-cycle request to draw a new secret.
- seed_load  in  1  load `seed` into the LFSR this cycle.
- seed  in  7  seed value.
- actual_number  out  7  latched secret, to the comparator.
- number_valid  out  1  1 = `actual_number` is stable and legal.
- draw_busy  out  1  1 while in DRAW.

Behaviour:
- Reset state:
  - lfsr = SEED_DEFAULT, state = DRAW, actual_number = 0, number_valid = 0, draw_busy = 1, try_cnt = 0.
  - A draw therefore starts automatically after reset release.
- LFSR:
  - Advances every cycle, in every state: next = {lfsr[5:0], lfsr[6]^lfsr[5]} (x^7+x^6+1, period 127).
  - seed_load overrides the advance: lfsr <= seed. If seed == 0, load 7'h01 instead (avoids lock-up).
- State DRAW (draw_busy = 1, number_valid = 0):
  - Each cycle, test the current lfsr register value.
  - If MIN_VAL <= lfsr <= MAX_VAL: actual_number <= lfsr, number_valid <= 1, try_cnt <= 0, go to READY.
  - Else if try_cnt == MAX_TRIES-1: actual_number <= MIN_VAL, number_valid <= 1, try_cnt <= 0, go to READY.
  - Else: try_cnt <= try_cnt+1.
  - new_game is ignored while in DRAW.
- State READY (draw_busy = 0, number_valid = 1):
  - actual_number holds its value.
  - new_game = 1: number_valid <= 0, actual_number <= 0, try_cnt <= 0, go to DRAW.
- Latency: new_game sampled at edge N; earliest valid secret visible after edge N+1 (2 edges).
- seed_load and new_game in the same READY cycle: both take effect. The first DRAW cycle tests the loaded seed, so seed == secret if it is in range.
- seed_load during DRAW: the next DRAW cycle tests the loaded value; try_cnt is not cleared.
- Reset asserted mid-DRAW or mid-READY: immediate return to the reset state, independent of clk.
- Comparisons are unsigned 7-bit. try_cnt is 8 bits wide.

Decomposition:
- Shared game package holds:
  - NUM_W = 7
  - LFSR_TAP polynomial constant
  - state encoding DRAW = 1'b0, READY = 1'b1
  - default range constants 1/99, shared with the display stage
- One natural sub-module: lfsr7. It takes clk, reset, load, load_val and outputs the value. It includes the zero-seed substitution and has no other logic.
- Range check, try counter and FSM stay in secret_number_gen.

Test Plan:
1. Reset 3 cycles then release, defaults -> within 2 edges of release, draw_busy = 0, number_valid = 1, actual_number = 7'h5A (90, in range).
2. READY; assert new_game = 1, seed_load = 1, seed = 7'h05 for one cycle -> next edge: valid = 0, busy = 1. Following edge: actual_number = 5, valid = 1.
3. Same as 2 with seed = 7'h70 (112, out of range) -> first DRAW cycle rejects. Next value 7'h60 = 96 is accepted: actual_number = 96, valid = 1 three edges after the request.
4. MIN_VAL = MAX_VAL = 100, MAX_TRIES = 4, seed = 7'h01 with new_game -> tested values 1, 2, 4, 8 are all rejected. After the 4th DRAW cycle, actual_number = 100 (fallback), valid = 1.
5. seed_load with seed = 0 plus new_game -> LFSR holds 1 (not 0). actual_number = 1 (MIN_VAL = 1), and the LFSR keeps advancing afterwards.
6. new_game pulsed during DRAW -> ignored, and only one draw completes. reset pulsed low mid-DRAW -> valid = 0 and actual_number = 0 immediately, then LFSR = 7'h5A after release.
